// File: rtl/channel_test_sequencer.sv
// ============================================================================
// channel_test_sequencer : run controller for one generator/checker test pass
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_test_sequencer #(
    parameter logic [19:0] START_DELAY    = 20'd20000,
    parameter logic [15:0] NUM_WORDS      = 16'd256,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
    parameter logic [3:0]  DRAIN_CYCLES   = 4'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        gen_start,
    output logic [15:0] gen_num_words,
    output logic        chk_clear,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    output logic        rx_tready,
    input  logic [3:0]  err_count,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] beat_count,
    output logic [3:0]  err_snapshot
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] delay_cnt_q, delay_cnt_d;
    logic [15:0] watchdog_q, watchdog_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] beat_count_q, beat_count_d;
    logic        last_tlast_q, last_tlast_d;
    logic        timeout_q, timeout_d;
    logic        pass_q, pass_d;
    logic [3:0]  err_snapshot_q, err_snapshot_d;
    logic        gen_start_q, gen_start_d;
    logic        chk_clear_q, chk_clear_d;
    logic        rx_tready_q, rx_tready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        w_beat;

    assign w_beat = rx_tvalid & rx_tready_q;

    always_comb begin
        state_d        = state_q;
        delay_cnt_d    = delay_cnt_q;
        watchdog_d     = watchdog_q;
        drain_cnt_d    = drain_cnt_q;
        beat_count_d   = beat_count_q;
        last_tlast_d   = last_tlast_q;
        timeout_d      = timeout_q;
        pass_d         = pass_q;
        err_snapshot_d = err_snapshot_q;
        chk_clear_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_WARMUP;
                    chk_clear_d    = 1'b1;
                    delay_cnt_d    = 20'd0;
                    beat_count_d   = 16'd0;
                    last_tlast_d   = 1'b0;
                    timeout_d      = 1'b0;
                    pass_d         = 1'b0;
                    err_snapshot_d = 4'd0;
                end
            end
            ST_WARMUP: begin
                if (delay_cnt_q == START_DELAY - 20'd1) begin
                    state_d = ST_LAUNCH;
                end else begin
                    delay_cnt_d = delay_cnt_q + 20'd1;
                end
            end
            ST_LAUNCH: begin
                watchdog_d = 16'd0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                // A beat always takes priority over the watchdog expiring.
                if (w_beat) begin
                    beat_count_d = beat_count_q + 16'd1;
                    watchdog_d   = 16'd0;
                    last_tlast_d = rx_tlast;
                    if (rx_tlast || (beat_count_q + 16'd1 == NUM_WORDS)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 4'd0;
                    end
                end else if (watchdog_q == TIMEOUT_CYCLES - 16'd1) begin
                    timeout_d   = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 4'd0;
                end else begin
                    watchdog_d = watchdog_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_CYCLES - 4'd1) begin
                    err_snapshot_d = err_count;
                    pass_d         = (err_count == 4'd0) && !timeout_q &&
                                     (beat_count_q == NUM_WORDS) && last_tlast_q;
                    state_d        = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        gen_start_d = (state_d == ST_LAUNCH);
        rx_tready_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_WARMUP) || (state_d == ST_LAUNCH) ||
                      (state_d == ST_RUN)    || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            delay_cnt_q    <= 20'd0;
            watchdog_q     <= 16'd0;
            drain_cnt_q    <= 4'd0;
            beat_count_q   <= 16'd0;
            last_tlast_q   <= 1'b0;
            timeout_q      <= 1'b0;
            pass_q         <= 1'b0;
            err_snapshot_q <= 4'd0;
            gen_start_q    <= 1'b0;
            chk_clear_q    <= 1'b0;
            rx_tready_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_cnt_q    <= delay_cnt_d;
            watchdog_q     <= watchdog_d;
            drain_cnt_q    <= drain_cnt_d;
            beat_count_q   <= beat_count_d;
            last_tlast_q   <= last_tlast_d;
            timeout_q      <= timeout_d;
            pass_q         <= pass_d;
            err_snapshot_q <= err_snapshot_d;
            gen_start_q    <= gen_start_d;
            chk_clear_q    <= chk_clear_d;
            rx_tready_q    <= rx_tready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign gen_num_words = NUM_WORDS;
    assign gen_start     = gen_start_q;
    assign chk_clear     = chk_clear_q;
    assign rx_tready     = rx_tready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign beat_count    = beat_count_q;
    assign err_snapshot  = err_snapshot_q;

endmodule

`default_nettype wire
